// File: rtl/dram_wb_if.sv
// Wishbone B4 classic-cycle bus between the pattern tester and the LiteDRAM user port.
interface dram_wb_if #(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned ADDR_WIDTH = 25
);
    logic                    cyc;
    logic                    stb;
    logic                    we;
    logic [ADDR_WIDTH-1:0]   adr;
    logic [DATA_WIDTH-1:0]   dat_w;
    logic [DATA_WIDTH/8-1:0] sel;
    logic [DATA_WIDTH-1:0]   dat_r;
    logic                    ack;
    logic                    err;

    modport master (
        output cyc, stb, we, adr, dat_w, sel,
        input  dat_r, ack, err
    );

    modport slave (
        input  cyc, stb, we, adr, dat_w, sel,
        output dat_r, ack, err
    );
endinterface

// File: rtl/dram_wb_pattern_tester.sv
// Writes a fixed pattern bank to DRAM over Wishbone, reads it back and reports pass/fail/timeout.
module dram_wb_pattern_tester #(
    parameter int unsigned DATA_WIDTH     = 256,
    parameter int unsigned ADDR_WIDTH     = 25,
    parameter int unsigned NUM_WORDS      = 16,
    parameter int unsigned BASE_ADDR      = 0,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                  user_clk,
    input  logic                  user_rst,
    input  logic                  init_done,
    input  logic                  start,
    dram_wb_if.master             wb,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  fail,
    output logic                  timeout,
    output logic [15:0]           err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr
);
    typedef enum logic [2:0] {
        StIdle, StWaitInit, StWrReq, StWrWait, StRdReq, StRdWait, StCheck, StDone
    } state_e;

    localparam logic [15:0] LastIdx = 16'(NUM_WORDS - 1);

    state_e                  state_q;
    logic [15:0]             idx_q;
    logic [3:0]              pat_q;
    logic [31:0]             tmo_q;
    logic [DATA_WIDTH-1:0]   rdata_q;

    logic [ADDR_WIDTH-1:0]   cur_adr;
    logic [DATA_WIDTH-1:0]   exp_word;
    logic [15:0]             err_count_inc;
    logic [3:0]              next_pat;
    logic                    last, ack_hit, err_hit, tmo_hit, mismatch;

    // Pattern P[pat] replicated across the bus, low word replaced by the index to expose aliasing.
    function automatic logic [DATA_WIDTH-1:0] expected_word(input logic [3:0] pat,
                                                            input logic [15:0] idx);
        logic [127:0]          p;
        logic [DATA_WIDTH-1:0] w;
        case (pat)
            4'd0:    p = {16{8'hA5}};
            4'd1:    p = {16{8'h5A}};
            4'd2:    p = {16{8'hFF}};
            4'd3:    p = {16{8'h00}};
            4'd4:    p = {16{8'hF0}};
            4'd5:    p = {16{8'h0F}};
            4'd6:    p = {16{8'hAA}};
            4'd7:    p = {16{8'h55}};
            default: p = 128'hAABB_CCDD_EEFF_0011_2233_4455_6677_8899;
        endcase
        for (int k = 0; k < int'(DATA_WIDTH / 128); k++) w[k*128 +: 128] = p;
        w[31:0] = {16'h0000, idx};
        return w;
    endfunction

    assign cur_adr       = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(idx_q);
    assign exp_word      = expected_word(pat_q, idx_q);
    assign err_count_inc = (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;
    assign next_pat      = (pat_q == 4'd8) ? 4'd0 : pat_q + 4'd1;
    assign last          = (idx_q == LastIdx);
    assign err_hit       = wb.stb && wb.err;
    assign ack_hit       = wb.stb && wb.ack && !wb.err;
    assign tmo_hit       = (tmo_q >= TIMEOUT_CYCLES - 1);
    assign mismatch      = (rdata_q != exp_word);

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state_q        <= StIdle;
            idx_q          <= '0;
            pat_q          <= '0;
            tmo_q          <= '0;
            rdata_q        <= '0;
            wb.cyc         <= 1'b0;
            wb.stb         <= 1'b0;
            wb.we          <= 1'b0;
            wb.adr         <= '0;
            wb.dat_w       <= '0;
            wb.sel         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail           <= 1'b0;
            timeout        <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q        <= StWaitInit;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        fail           <= 1'b0;
                        timeout        <= 1'b0;
                        err_count      <= '0;
                        first_err_addr <= '0;
                        idx_q          <= '0;
                        pat_q          <= '0;
                    end
                end
                StWaitInit: begin
                    if (init_done) state_q <= StWrReq;
                end
                StWrReq, StRdReq: begin
                    wb.cyc  <= 1'b1;
                    wb.stb  <= 1'b1;
                    wb.we   <= (state_q == StWrReq);
                    wb.adr  <= cur_adr;
                    wb.sel  <= '1;
                    tmo_q   <= '0;
                    if (state_q == StWrReq) begin
                        wb.dat_w <= exp_word;
                        state_q  <= StWrWait;
                    end else begin
                        state_q  <= StRdWait;
                    end
                end
                StWrWait, StRdWait: begin
                    if (err_hit || ack_hit) begin
                        wb.cyc <= 1'b0;
                        wb.stb <= 1'b0;
                        wb.sel <= '0;
                        if (ack_hit && state_q == StRdWait) begin
                            rdata_q <= wb.dat_r;
                            state_q <= StCheck;
                        end else begin
                            if (err_hit) begin
                                err_count <= err_count_inc;
                                if (err_count == '0) first_err_addr <= cur_adr;
                            end
                            if (!last) begin
                                idx_q   <= idx_q + 16'd1;
                                pat_q   <= next_pat;
                                state_q <= (state_q == StWrWait) ? StWrReq : StRdReq;
                            end else if (state_q == StWrWait) begin
                                idx_q   <= '0;
                                pat_q   <= '0;
                                state_q <= StRdReq;
                            end else begin
                                // Read error on the last word: the run already has an error.
                                state_q <= StDone;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                pass    <= 1'b0;
                                fail    <= 1'b1;
                            end
                        end
                    end else if (tmo_hit) begin
                        wb.cyc    <= 1'b0;
                        wb.stb    <= 1'b0;
                        wb.sel    <= '0;
                        timeout   <= 1'b1;
                        err_count <= err_count_inc;
                        if (err_count == '0) first_err_addr <= cur_adr;
                        state_q   <= StDone;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        pass      <= 1'b0;
                        fail      <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 32'd1;
                    end
                end
                StCheck: begin
                    if (mismatch) begin
                        err_count <= err_count_inc;
                        if (err_count == '0) first_err_addr <= cur_adr;
                    end
                    if (last) begin
                        state_q <= StDone;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (err_count == '0) && !mismatch && !timeout;
                        fail    <= !((err_count == '0) && !mismatch && !timeout);
                    end else begin
                        idx_q   <= idx_q + 16'd1;
                        pat_q   <= next_pat;
                        state_q <= StRdReq;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dram_wb_pattern_tester.sv
// Scoreboard bench: expected bus transactions and run results are queued, monitors pop and compare.
module tb_dram_wb_pattern_tester;
    localparam int DW   = 256;
    localparam int AW   = 25;
    localparam int NW   = 16;
    localparam int BASE = 32'h40;
    localparam int TMO  = 10;

    typedef struct { bit we; int idx; int len; bit acked; } txn_t;
    typedef struct { bit pass; bit fail; bit tmo; int errs; int first; } st_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          user_rst = 1'b1;
    logic          init_done = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, pass, fail, timeout;
    logic [15:0]   err_count;
    logic [AW-1:0] first_err_addr;

    dram_wb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    dram_wb_pattern_tester #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WORDS(NW), .BASE_ADDR(BASE),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .user_clk(clk), .user_rst(user_rst), .init_done(init_done), .start(start), .wb(bus),
        .busy(busy), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
        .err_count(err_count), .first_err_addr(first_err_addr)
    );

    int n_cmp = 0;
    int n_bad = 0;
    txn_t exp_q[$];
    st_t  st_q[$];

    function automatic void chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [DW-1:0] exp_data(int i);
        logic [7:0]    b;
        logic [127:0]  p;
        logic [DW-1:0] w;
        case (i % 9)
            0: b = 8'hA5;  1: b = 8'h5A;  2: b = 8'hFF;  3: b = 8'h00;
            4: b = 8'hF0;  5: b = 8'h0F;  6: b = 8'hAA;  default: b = 8'h55;
        endcase
        p = (i % 9 == 8) ? 128'hAABB_CCDD_EEFF_0011_2233_4455_6677_8899 : {16{b}};
        w = {p, p};
        w[31:0] = i;
        return w;
    endfunction

    // Slave memory model with configurable ack latency and optional readback corruption.
    int            lat = 0;
    bit            never_ack = 1'b0;
    int            corrupt = -1;
    int            wcnt = 0;
    logic [DW-1:0] mem [NW];
    logic [AW-1:0] off;

    assign off     = bus.adr - AW'(BASE);
    assign bus.ack = bus.stb && !never_ack && (wcnt == lat);
    assign bus.err = 1'b0;

    always_comb begin
        bus.dat_r = '0;
        if (off < AW'(NW)) bus.dat_r = mem[off[3:0]];
        if (!bus.we && int'(off) == corrupt) bus.dat_r[100] = ~bus.dat_r[100];
    end

    always @(posedge clk) begin
        if (!bus.stb || bus.ack) wcnt <= 0;
        else wcnt <= wcnt + 1;
        if (bus.stb && bus.ack && bus.we && off < AW'(NW)) mem[off[3:0]] <= bus.dat_w;
    end

    // Bus monitor: one transaction per stb high period.
    bit            in_txn = 1'b0, t_we, t_acked, t_stable, sel_idle_bad = 1'b0;
    int            t_len;
    logic [AW-1:0] t_adr;
    logic [DW-1:0] t_dat;
    txn_t          e;

    initial begin
        forever begin
            @(negedge clk);
            if (bus.stb) begin
                if (!in_txn) begin
                    in_txn = 1'b1; t_len = 0; t_acked = 1'b0; t_stable = 1'b1;
                    t_we = bus.we; t_adr = bus.adr; t_dat = bus.dat_w;
                end
                t_len++;
                if (bus.we !== t_we || bus.adr !== t_adr || bus.dat_w !== t_dat ||
                    bus.sel !== '1 || bus.cyc !== 1'b1) t_stable = 1'b0;
                if (bus.ack) t_acked = 1'b1;
            end else begin
                if (bus.sel !== '0) sel_idle_bad = 1'b1;
                if (in_txn) begin
                    in_txn = 1'b0;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_txn", t_adr, '1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("txn_we", t_we, e.we);
                        chk("txn_adr", t_adr, AW'(BASE + e.idx));
                        if (e.we) chk("txn_dat", t_dat, exp_data(e.idx));
                        if (t_we && t_adr == AW'(BASE + 9))
                            chk("word9_dat", t_dat, {{28{8'hA5}}, 32'h0000_0009});
                        chk("txn_len", t_len, e.len);
                        chk("txn_acked", t_acked, e.acked);
                        chk("txn_stable", t_stable, 1'b1);
                    end
                end
            end
        end
    end

    // Result monitor: compares status when done rises.
    bit  done_prev = 1'b0;
    st_t s;
    initial begin
        forever begin
            @(negedge clk);
            if (done && !done_prev) begin
                if (st_q.size() == 0) begin
                    chk("unexpected_done", done, 1'b0);
                end else begin
                    s = st_q.pop_front();
                    chk("st_pass", pass, s.pass);
                    chk("st_fail", fail, s.fail);
                    chk("st_timeout", timeout, s.tmo);
                    chk("st_err_count", err_count, s.errs);
                    chk("st_first_err_addr", first_err_addr, AW'(s.first));
                    chk("st_busy", busy, 1'b0);
                end
            end
            done_prev = done;
        end
    end

    task automatic push_run(input int l, input bit ok, input int errs, input int first);
        for (int i = 0; i < NW; i++) exp_q.push_back('{1'b1, i, l + 1, 1'b1});
        for (int i = 0; i < NW; i++) exp_q.push_back('{1'b0, i, l + 1, 1'b1});
        st_q.push_back('{ok, !ok, 1'b0, errs, first});
    endtask

    task automatic run_start(input bit check_timing);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        if (check_timing) begin
            chk("start_busy", busy, 1'b1);
            chk("start_cyc_e0", bus.cyc, 1'b0);
            @(posedge clk); #1 chk("start_cyc_e1", bus.cyc, 1'b0);
            @(posedge clk); #1 chk("start_cyc_e2", bus.cyc, 1'b1);
        end
    endtask

    task automatic wait_done(input string tag);
        bit got = 1'b0;
        for (int k = 0; k < 4000 && !got; k++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        chk({tag, "_done_seen"}, got, 1'b1);
        @(negedge clk);
        chk({tag, "_txn_q_empty"}, exp_q.size(), 0);
        chk({tag, "_st_q_empty"}, st_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        n_bad++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        int  cyc_seen, busy_low;
        bit  hit;
        repeat (3) @(posedge clk);
        #1 user_rst = 1'b0;
        @(negedge clk);
        chk("rst_cyc", bus.cyc, 1'b0);
        chk("rst_stb", bus.stb, 1'b0);
        chk("rst_we", bus.we, 1'b0);
        chk("rst_sel", bus.sel, '0);
        chk("rst_adr", bus.adr, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_pass", pass, 1'b0);
        chk("rst_fail", fail, 1'b0);
        chk("rst_timeout", timeout, 1'b0);
        chk("rst_err_count", err_count, 16'h0);
        chk("rst_first_err", first_err_addr, '0);

        // Zero-wait slave, clean run.
        lat = 0;
        push_run(0, 1'b1, 0, 0);
        run_start(1'b1);
        wait_done("zero_wait");

        // Five-cycle ack latency; a start pulse mid-run must be ignored.
        lat = 5;
        push_run(5, 1'b1, 0, 0);
        run_start(1'b1);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done("latency5");

        // Bit 100 of word 3 corrupted on readback.
        lat = 0;
        corrupt = 3;
        push_run(0, 1'b0, 1, BASE + 3);
        run_start(1'b0);
        wait_done("corrupt");
        corrupt = -1;

        // Slave never acks: abort on word 0 after TMO cycles.
        never_ack = 1'b1;
        exp_q.push_back('{1'b1, 0, TMO, 1'b0});
        st_q.push_back('{1'b0, 1'b1, 1'b1, 1, BASE});
        run_start(1'b1);
        wait_done("timeout");
        never_ack = 1'b0;

        // Calibration held off for 50 cycles.
        init_done = 1'b0;
        push_run(0, 1'b1, 0, 0);
        run_start(1'b0);
        cyc_seen = 0;
        busy_low = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.cyc) cyc_seen++;
            if (!busy) busy_low++;
        end
        chk("init_wait_no_cyc", cyc_seen, 0);
        chk("init_wait_busy", busy_low, 0);
        init_done = 1'b1;
        wait_done("init_wait");

        // Reset during word 7's write wait.
        lat = 5;
        for (int i = 0; i < 7; i++) exp_q.push_back('{1'b1, i, 6, 1'b1});
        exp_q.push_back('{1'b1, 7, 1, 1'b0});
        run_start(1'b0);
        hit = 1'b0;
        for (int k = 0; k < 2000 && !hit; k++) begin
            @(negedge clk);
            if (bus.stb && bus.we && bus.adr == AW'(BASE + 7)) hit = 1'b1;
        end
        chk("reset_word7_seen", hit, 1'b1);
        #1 user_rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_cyc", bus.cyc, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        user_rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_txn_q_empty", exp_q.size(), 0);

        // Clean run after the reset.
        lat = 0;
        push_run(0, 1'b1, 0, 0);
        run_start(1'b1);
        wait_done("after_reset");

        chk("sel_idle_zero", sel_idle_bad, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
